mdio_responder: RTL and testbench

MDIO_RESPONDER -- requirements
Module: mdio_responder

---
 rtl/mdio_responder_if.sv | 27 ++
 rtl/mdio_responder.sv | 195 +++++++++++++++++++
 tb/tb_mdio_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_responder_if.sv
// rtl/mdio_responder_if.sv - MDIO pad and register-file bundle for mdio_responder
interface mdio_responder_if;
  logic        ip_mdio_clk;
  logic        ip_mdio_data;
  logic        op_mdio_data;
  logic        op_mdio_data_oe;
  logic [4:0]  ip_phy_addr;
  logic [4:0]  op_reg_addr;
  logic        op_reg_rd_strobe;
  logic [15:0] ip_reg_rd_data;
  logic        op_reg_wr_strobe;
  logic [15:0] op_reg_wr_data;
  logic        op_busy;
  logic        op_frame_error;

  modport slave (
    input  ip_mdio_clk, ip_mdio_data, ip_phy_addr, ip_reg_rd_data,
    output op_mdio_data, op_mdio_data_oe, op_reg_addr, op_reg_rd_strobe,
    output op_reg_wr_strobe, op_reg_wr_data, op_busy, op_frame_error
  );

  modport master (
    output ip_mdio_clk, ip_mdio_data, ip_phy_addr, ip_reg_rd_data,
    input  op_mdio_data, op_mdio_data_oe, op_reg_addr, op_reg_rd_strobe,
    input  op_reg_wr_strobe, op_reg_wr_data, op_busy, op_frame_error
  );
endinterface

// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - Clause-22 style MDIO responder with register-file strobes
module mdio_responder #(
  parameter int MIN_PREAMBLE   = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               ip_master_clk,
  input  logic               ip_sync_reset,
  mdio_responder_if.slave    bus
);
  localparam int PW = $clog2(MIN_PREAMBLE + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SFD2, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA
  } state_t;

  state_t      state_q;
  logic        mdc_s1_q, mdc_s2_q, mdc_s3_q, mdi_s1_q, mdi_s2_q;
  logic [PW-1:0] pre_cnt_q;
  logic [WW-1:0] wd_q;
  logic [3:0]  bit_cnt_q;
  logic        op_hi_q, is_read_q;
  logic [4:0]  phy_sh_q, reg_addr_q;
  logic [15:0] tx_sh_q, wr_sh_q, wr_data_q;
  logic        mdo_q, oe_q, busy_q, rd_stb_q, wr_stb_q, err_q;
  logic        bit_evt, bit_val;

  assign bit_evt = mdc_s2_q & ~mdc_s3_q;
  assign bit_val = mdi_s2_q;

  assign bus.op_mdio_data     = mdo_q;
  assign bus.op_mdio_data_oe  = oe_q;
  assign bus.op_reg_addr      = reg_addr_q;
  assign bus.op_reg_rd_strobe = rd_stb_q;
  assign bus.op_reg_wr_strobe = wr_stb_q;
  assign bus.op_reg_wr_data   = wr_data_q;
  assign bus.op_busy          = busy_q;
  assign bus.op_frame_error   = err_q;

  always_ff @(posedge ip_master_clk) begin
    if (ip_sync_reset) begin
      state_q    <= S_IDLE;
      mdc_s1_q   <= 1'b1;
      mdc_s2_q   <= 1'b1;
      mdc_s3_q   <= 1'b1;
      mdi_s1_q   <= 1'b1;
      mdi_s2_q   <= 1'b1;
      pre_cnt_q  <= '0;
      wd_q       <= '0;
      bit_cnt_q  <= '0;
      op_hi_q    <= 1'b0;
      is_read_q  <= 1'b0;
      phy_sh_q   <= '0;
      reg_addr_q <= '0;
      tx_sh_q    <= '0;
      wr_sh_q    <= '0;
      wr_data_q  <= '0;
      mdo_q      <= 1'b1;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rd_stb_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mdc_s1_q <= bus.ip_mdio_clk;
      mdc_s2_q <= mdc_s1_q;
      mdc_s3_q <= mdc_s2_q;
      mdi_s1_q <= bus.ip_mdio_data;
      mdi_s2_q <= mdi_s1_q;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      err_q    <= 1'b0;

      if (bit_evt) begin
        wd_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (bit_val) begin
              if (pre_cnt_q < PW'(MIN_PREAMBLE)) pre_cnt_q <= pre_cnt_q + PW'(1);
            end else begin
              pre_cnt_q <= '0;
              if (pre_cnt_q >= PW'(MIN_PREAMBLE)) state_q <= S_SFD2;
            end
          end
          S_SFD2: begin
            bit_cnt_q <= '0;
            if (bit_val) state_q <= S_OP;
            else begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          S_OP: begin
            if (bit_cnt_q == 4'd0) begin
              op_hi_q   <= bit_val;
              bit_cnt_q <= 4'd1;
            end else begin
              bit_cnt_q <= '0;
              if (op_hi_q ^ bit_val) begin
                is_read_q <= op_hi_q;
                state_q   <= S_PHYAD;
              end else begin
                err_q   <= 1'b1;
                state_q <= S_IDLE;
              end
            end
          end
          S_PHYAD: begin
            phy_sh_q <= {phy_sh_q[3:0], bit_val};
            if (bit_cnt_q == 4'd4) begin
              bit_cnt_q <= '0;
              // The address is only compared here, so later changes cannot disturb this frame.
              if ({phy_sh_q[3:0], bit_val} == bus.ip_phy_addr) begin
                busy_q  <= 1'b1;
                state_q <= S_REGAD;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          S_REGAD: begin
            reg_addr_q <= {reg_addr_q[3:0], bit_val};
            if (bit_cnt_q == 4'd4) begin
              bit_cnt_q <= '0;
              rd_stb_q  <= is_read_q;
              state_q   <= S_TA;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          S_TA: begin
            if (bit_cnt_q == 4'd0) begin
              bit_cnt_q <= 4'd1;
              if (is_read_q) begin
                tx_sh_q <= bus.ip_reg_rd_data;
                oe_q    <= 1'b1;
                mdo_q   <= 1'b0;
              end
            end else begin
              bit_cnt_q <= '0;
              if (is_read_q) begin
                mdo_q   <= tx_sh_q[15];
                tx_sh_q <= {tx_sh_q[14:0], 1'b0};
                state_q <= S_RDATA;
              end else begin
                state_q <= S_WDATA;
              end
            end
          end
          S_RDATA: begin
            if (bit_cnt_q == 4'd15) begin
              bit_cnt_q <= '0;
              oe_q      <= 1'b0;
              mdo_q     <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              mdo_q     <= tx_sh_q[15];
              tx_sh_q   <= {tx_sh_q[14:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          S_WDATA: begin
            wr_sh_q <= {wr_sh_q[14:0], bit_val};
            if (bit_cnt_q == 4'd15) begin
              bit_cnt_q <= '0;
              wr_data_q <= {wr_sh_q[14:0], bit_val};
              wr_stb_q  <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        // MDC stalled mid-frame: abandon without any strobe and release the pad.
        if (wd_q >= WW'(TIMEOUT_CYCLES - 1)) begin
          wd_q      <= '0;
          state_q   <= S_IDLE;
          pre_cnt_q <= '0;
          bit_cnt_q <= '0;
          oe_q      <= 1'b0;
          mdo_q     <= 1'b1;
          busy_q    <= 1'b0;
        end else begin
          wd_q <= wd_q + WW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_mdio_responder.sv
// tb/tb_mdio_responder.sv - directed self-checking bench for mdio_responder
module tb_mdio_responder;
  localparam int TMO = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mdio_responder_if ifc ();

  mdio_responder #(.MIN_PREAMBLE(32), .TIMEOUT_CYCLES(TMO)) dut (
    .ip_master_clk (clk),
    .ip_sync_reset (rst),
    .bus           (ifc)
  );

  // Monotone event counters; tests compare deltas across a scenario.
  int rd_cnt = 0, wr_cnt = 0, err_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  logic [4:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;

  always @(negedge clk) begin
    if (ifc.op_reg_rd_strobe === 1'b1) begin
      rd_cnt++;
      last_rd_addr = ifc.op_reg_addr;
    end
    if (ifc.op_reg_wr_strobe === 1'b1) begin
      wr_cnt++;
      last_wr_addr = ifc.op_reg_addr;
      last_wr_data = ifc.op_reg_wr_data;
    end
    if (ifc.op_frame_error === 1'b1) err_cnt++;
    if (ifc.op_mdio_data_oe === 1'b1) oe_cnt++;
    if (ifc.op_busy === 1'b1) busy_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic s_oe, output logic s_d);
    @(negedge clk);
    ifc.ip_mdio_clk  = 1'b0;
    ifc.ip_mdio_data = b;
    repeat (5) @(negedge clk);
    s_oe = ifc.op_mdio_data_oe;
    s_d  = ifc.op_mdio_data;
    ifc.ip_mdio_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic so, sd;
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], so, sd);
  endtask

  task automatic send_write(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
    send_bits(32'hFFFF_FFFF, 32);
    send_bits({18'd0, 2'b01, 2'b01, phy, ra}, 14);
    send_bits({14'd0, 2'b10, d}, 18);
  endtask

  task automatic test_reset;
    ifc.ip_mdio_clk = 1'b1;
    ifc.ip_mdio_data = 1'b1;
    ifc.ip_phy_addr = 5'h01;
    ifc.ip_reg_rd_data = 16'h0000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_oe", ifc.op_mdio_data_oe, 0);
    chk("reset_mdo", ifc.op_mdio_data, 1);
    chk("reset_busy", ifc.op_busy, 0);
    chk("reset_reg_addr", ifc.op_reg_addr, 0);
    chk("reset_wr_data", ifc.op_reg_wr_data, 0);
    chk("reset_strobes", {ifc.op_reg_rd_strobe, ifc.op_reg_wr_strobe, ifc.op_frame_error}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_oe", ifc.op_mdio_data_oe, 0);
  endtask

  task automatic test_write;
    int wr0 = wr_cnt, rd0 = rd_cnt, oe0 = oe_cnt, b0 = busy_cnt;
    send_write(5'h01, 5'd3, 16'hA5C3);
    repeat (6) @(negedge clk);
    chk("wr_strobe_count", wr_cnt - wr0, 1);
    chk("wr_no_read", rd_cnt - rd0, 0);
    chk("wr_addr", last_wr_addr, 3);
    chk("wr_data", last_wr_data, 16'hA5C3);
    chk("wr_oe_never", oe_cnt - oe0, 0);
    chk("wr_busy_seen", (busy_cnt - b0) > 0, 1);
    chk("wr_busy_end", ifc.op_busy, 0);
  endtask

  task automatic test_read;
    int rd0 = rd_cnt, wr0 = wr_cnt;
    logic [15:0] word = 16'h1234;
    logic so, sd;
    ifc.ip_reg_rd_data = word;
    send_bits(32'hFFFF_FFFF, 32);
    send_bits({18'd0, 2'b01, 2'b10, 5'h01, 5'd2}, 14);
    send_bit(1'b1, so, sd);
    chk("rd_ta1_oe", so, 0);
    send_bit(1'b1, so, sd);
    chk("rd_ta2_bus", {so, sd}, 2'b10);
    for (int i = 0; i < 16; i++) begin
      send_bit(1'b1, so, sd);
      chk($sformatf("rd_bit%0d", 15 - i), {so, sd}, {1'b1, word[15 - i]});
    end
    repeat (6) @(negedge clk);
    chk("rd_oe_release", ifc.op_mdio_data_oe, 0);
    chk("rd_mdo_idle", ifc.op_mdio_data, 1);
    chk("rd_busy_end", ifc.op_busy, 0);
    chk("rd_strobe_count", rd_cnt - rd0, 1);
    chk("rd_addr", last_rd_addr, 2);
    chk("rd_no_write", wr_cnt - wr0, 0);
  endtask

  task automatic test_phy_change;
    int wr0 = wr_cnt;
    send_bits(32'hFFFF_FFFF, 32);
    send_bits({18'd0, 2'b01, 2'b01, 5'h01, 5'd9}, 14);
    ifc.ip_phy_addr = 5'h02;
    send_bits({14'd0, 2'b10, 16'h5A5A}, 18);
    repeat (6) @(negedge clk);
    ifc.ip_phy_addr = 5'h01;
    chk("phychg_wr_count", wr_cnt - wr0, 1);
    chk("phychg_addr", last_wr_addr, 9);
    chk("phychg_data", last_wr_data, 16'h5A5A);
  endtask

  task automatic test_mismatch;
    int wr0 = wr_cnt, rd0 = rd_cnt, oe0 = oe_cnt, b0 = busy_cnt;
    send_write(5'h07, 5'd3, 16'h0000);
    repeat (6) @(negedge clk);
    chk("mis_strobes", (wr_cnt - wr0) + (rd_cnt - rd0), 0);
    chk("mis_oe", oe_cnt - oe0, 0);
    chk("mis_busy", busy_cnt - b0, 0);
  endtask

  task automatic test_bad_frame;
    int wr0 = wr_cnt, e0 = err_cnt;
    send_bits(32'h7FFF_FFFF, 31);
    send_bits({18'd0, 2'b01, 2'b01, 5'h01, 5'd3}, 14);
    send_bits({14'd0, 2'b10, 16'h0000}, 18);
    repeat (6) @(negedge clk);
    chk("short_pre_no_write", wr_cnt - wr0, 0);
    chk("short_pre_no_err", err_cnt - e0, 0);
    e0 = err_cnt;
    send_bits(32'hFFFF_FFFF, 32);
    send_bits(32'h0, 2);
    repeat (6) @(negedge clk);
    chk("bad_sfd_err", err_cnt - e0, 1);
    e0 = err_cnt;
    send_bits(32'hFFFF_FFFF, 32);
    send_bits({28'd0, 2'b01, 2'b11}, 4);
    repeat (6) @(negedge clk);
    chk("bad_op_err", err_cnt - e0, 1);
    chk("bad_op_busy", ifc.op_busy, 0);
  endtask

  task automatic test_timeout;
    int wr0 = wr_cnt;
    logic [15:0] word = 16'hBEEF;
    logic so, sd;
    ifc.ip_reg_rd_data = word;
    send_bits(32'hFFFF_FFFF, 32);
    send_bits({18'd0, 2'b01, 2'b10, 5'h01, 5'd4}, 14);
    send_bits(32'h3, 2);
    for (int i = 0; i < 8; i++) send_bit(1'b1, so, sd);
    chk("tmo_bit8", {so, sd}, {1'b1, word[8]});
    repeat (TMO - 60) @(negedge clk);
    chk("tmo_not_early", {ifc.op_mdio_data_oe, ifc.op_busy}, 2'b11);
    repeat (100) @(negedge clk);
    chk("tmo_oe", ifc.op_mdio_data_oe, 0);
    chk("tmo_busy", ifc.op_busy, 0);
    chk("tmo_mdo", ifc.op_mdio_data, 1);
    chk("tmo_no_write", wr_cnt - wr0, 0);
    send_write(5'h01, 5'd5, 16'h0F0F);
    repeat (6) @(negedge clk);
    chk("tmo_next_wr", wr_cnt - wr0, 1);
    chk("tmo_next_addr", last_wr_addr, 5);
    chk("tmo_next_data", last_wr_data, 16'h0F0F);
  endtask

  task automatic test_reset_mid_read;
    int wr0 = wr_cnt, oe0;
    logic so, sd;
    ifc.ip_reg_rd_data = 16'hCAFE;
    send_bits(32'hFFFF_FFFF, 32);
    send_bits({18'd0, 2'b01, 2'b10, 5'h01, 5'd6}, 14);
    send_bits(32'h3, 2);
    for (int i = 0; i < 4; i++) send_bit(1'b1, so, sd);
    chk("rst_mid_oe_before", ifc.op_mdio_data_oe, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_oe", ifc.op_mdio_data_oe, 0);
    chk("rst_mid_mdo", ifc.op_mdio_data, 1);
    chk("rst_mid_busy", ifc.op_busy, 0);
    rst = 1'b0;
    oe0 = oe_cnt;
    send_bits(32'hFFF, 12);
    repeat (6) @(negedge clk);
    chk("rst_mid_oe_after", oe_cnt - oe0, 0);
    chk("rst_mid_no_write", wr_cnt - wr0, 0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_phy_change();
    test_mismatch();
    test_bad_frame();
    test_timeout();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
